// File: rtl/hazard_bypass_unit_pkg.sv
// Shared constants and types for the hazard/bypass unit: default widths,
// the hardwired-zero register index and the forwarding-source encoding.
package hazard_bypass_unit_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_CNT_W  = 16;

    localparam int REG_ZERO = 0;

    // Which pipeline stage supplies an operand, highest priority first.
    typedef enum logic [1:0] {
        SRC_M    = 2'd0,
        SRC_W    = 2'd1,
        SRC_HIST = 2'd2,
        SRC_RF   = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/hazard_bypass_unit_fwd_mux.sv
// Single-port forwarding selector: the youngest matching producer wins
// (M, then W, then the registered write-back history), else the latched value.
module hazard_bypass_unit_fwd_mux
    import hazard_bypass_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic [REG_W-1:0]  src,
    input  logic [REG_W-1:0]  m_dst,
    input  logic              m_we,
    input  logic [DATA_W-1:0] m_data,
    input  logic [REG_W-1:0]  w_dst,
    input  logic              w_we,
    input  logic [DATA_W-1:0] w_data,
    input  logic [REG_W-1:0]  h_dst,
    input  logic              h_valid,
    input  logic [DATA_W-1:0] h_data,
    input  logic [DATA_W-1:0] rf_val,
    output logic [DATA_W-1:0] data
);

    fwd_src_e sel;
    logic     src_nz;

    assign src_nz = (src != REG_W'(REG_ZERO));

    always_comb begin
        sel = SRC_RF;
        if (src_nz && m_we && (src == m_dst)) begin
            sel = SRC_M;
        end else if (src_nz && w_we && (src == w_dst)) begin
            sel = SRC_W;
        end else if (src_nz && h_valid && (src == h_dst)) begin
            sel = SRC_HIST;
        end
    end

    always_comb begin
        data = rf_val;
        case (sel)
            SRC_M:    data = m_data;
            SRC_W:    data = w_data;
            SRC_HIST: data = h_data;
            default:  data = rf_val;
        endcase
    end

endmodule

// File: rtl/hazard_bypass_unit.sv
// Forwarding and interlock unit for the 5-stage pipeline: X-operand and store
// bypass, load-use and multdiv stalls, multdiv destination scoreboard, stall counter.
module hazard_bypass_unit
    import hazard_bypass_unit_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_W      = DEF_REG_W,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int WB_HIST_EN = 1,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*REG_W-1:0]  d_src,
    input  logic [NUM_RD-1:0]        d_src_used,
    input  logic [REG_W-1:0]         d_dst,
    input  logic                     d_we,
    input  logic                     d_is_md,
    input  logic [NUM_RD*REG_W-1:0]  x_src,
    input  logic [NUM_RD*DATA_W-1:0] x_val,
    input  logic [REG_W-1:0]         x_dst,
    input  logic                     x_we,
    input  logic                     x_is_load,
    input  logic [REG_W-1:0]         m_dst,
    input  logic                     m_we,
    input  logic [DATA_W-1:0]        m_data,
    input  logic [REG_W-1:0]         m_st_src,
    input  logic [DATA_W-1:0]        m_st_val,
    input  logic [REG_W-1:0]         w_dst,
    input  logic                     w_we,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     md_start,
    input  logic [REG_W-1:0]         md_dst,
    input  logic                     md_done,
    output logic [NUM_RD*DATA_W-1:0] x_fwd,
    output logic [DATA_W-1:0]        m_st_fwd,
    output logic                     stall,
    output logic                     md_busy,
    output logic [CNT_W-1:0]         stall_count
);

    localparam int NUM_REGS = 2 ** REG_W;

    logic                hist_valid_q, hist_valid_d;
    logic [REG_W-1:0]    hist_dst_q, hist_dst_d;
    logic [DATA_W-1:0]   hist_data_q, hist_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [REG_W-1:0]    md_owner_q, md_owner_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;
    logic                hist_en;
    logic                load_use, md_stall;

    assign hist_en = (WB_HIST_EN != 0) && hist_valid_q;

    // Instances 0..NUM_RD-1 serve X operands; the last serves store data at M,
    // where only W and history are younger producers.
    for (genvar i = 0; i <= NUM_RD; i++) begin : g_fwd
        if (i < NUM_RD) begin : g_x
            hazard_bypass_unit_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux (
                .src     (x_src[i*REG_W +: REG_W]),
                .m_dst   (m_dst),
                .m_we    (m_we),
                .m_data  (m_data),
                .w_dst   (w_dst),
                .w_we    (w_we),
                .w_data  (w_data),
                .h_dst   (hist_dst_q),
                .h_valid (hist_en),
                .h_data  (hist_data_q),
                .rf_val  (x_val[i*DATA_W +: DATA_W]),
                .data    (x_fwd[i*DATA_W +: DATA_W])
            );
        end else begin : g_st
            hazard_bypass_unit_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux (
                .src     (m_st_src),
                .m_dst   ('0),
                .m_we    (1'b0),
                .m_data  ('0),
                .w_dst   (w_dst),
                .w_we    (w_we),
                .w_data  (w_data),
                .h_dst   (hist_dst_q),
                .h_valid (hist_en),
                .h_data  (hist_data_q),
                .rf_val  (m_st_val),
                .data    (m_st_fwd)
            );
        end
    end

    always_comb begin
        load_use = 1'b0;
        md_stall = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (d_src_used[i]) begin
                if (x_is_load && x_we && (x_dst != REG_W'(REG_ZERO)) &&
                    (d_src[i*REG_W +: REG_W] == x_dst)) begin
                    load_use = 1'b1;
                end
                if (busy_q[d_src[i*REG_W +: REG_W]]) begin
                    md_stall = 1'b1;
                end
            end
        end
        if (d_we && busy_q[d_dst]) begin
            md_stall = 1'b1;
        end
        if (d_is_md && md_busy) begin
            md_stall = 1'b1;
        end
    end

    assign md_busy     = |busy_q;
    assign stall       = reset_n && (load_use || md_stall);
    assign stall_count = stall_count_q;

    always_comb begin
        hist_valid_d  = w_we && (w_dst != REG_W'(REG_ZERO));
        hist_dst_d    = w_dst;
        hist_data_d   = w_data;
        busy_d        = busy_q;
        md_owner_d    = md_owner_q;
        stall_count_d = stall_count_q;
        // Clear before set so a back-to-back op on the same register stays busy.
        if (md_done && md_busy) begin
            busy_d[md_owner_q] = 1'b0;
        end
        if (md_start && (md_dst != REG_W'(REG_ZERO))) begin
            busy_d[md_dst] = 1'b1;
            md_owner_d     = md_dst;
        end
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_valid_q  <= 1'b0;
            hist_dst_q    <= '0;
            hist_data_q   <= '0;
            busy_q        <= '0;
            md_owner_q    <= '0;
            stall_count_q <= '0;
        end else begin
            hist_valid_q  <= hist_valid_d;
            hist_dst_q    <= hist_dst_d;
            hist_data_q   <= hist_data_d;
            busy_q        <= busy_d;
            md_owner_q    <= md_owner_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed-vector bench for hazard_bypass_unit with an expected-value queue
// drained by an independent monitor on the falling clock edge.
module tb_hazard_bypass_unit;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int NUM_RD = 2;
    localparam int CNT_W  = 16;

    localparam int K_XF0 = 0, K_XF1 = 1, K_STF = 2, K_STALL = 3, K_BUSY = 4, K_CNT = 5;

    logic                     clock;
    logic                     reset_n;
    logic [NUM_RD*REG_W-1:0]  d_src;
    logic [NUM_RD-1:0]        d_src_used;
    logic [REG_W-1:0]         d_dst;
    logic                     d_we;
    logic                     d_is_md;
    logic [NUM_RD*REG_W-1:0]  x_src;
    logic [NUM_RD*DATA_W-1:0] x_val;
    logic [REG_W-1:0]         x_dst;
    logic                     x_we;
    logic                     x_is_load;
    logic [REG_W-1:0]         m_dst;
    logic                     m_we;
    logic [DATA_W-1:0]        m_data;
    logic [REG_W-1:0]         m_st_src;
    logic [DATA_W-1:0]        m_st_val;
    logic [REG_W-1:0]         w_dst;
    logic                     w_we;
    logic [DATA_W-1:0]        w_data;
    logic                     md_start;
    logic [REG_W-1:0]         md_dst;
    logic                     md_done;
    logic [NUM_RD*DATA_W-1:0] x_fwd;
    logic [DATA_W-1:0]        m_st_fwd;
    logic                     stall;
    logic                     md_busy;
    logic [CNT_W-1:0]         stall_count;

    logic [DATA_W-1:0] exp_q[$];
    int                kind_q[$];
    int                n_checks;
    int                n_pass;

    hazard_bypass_unit #(
        .DATA_W(DATA_W), .REG_W(REG_W), .NUM_RD(NUM_RD), .WB_HIST_EN(1), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .d_src(d_src), .d_src_used(d_src_used), .d_dst(d_dst), .d_we(d_we), .d_is_md(d_is_md),
        .x_src(x_src), .x_val(x_val), .x_dst(x_dst), .x_we(x_we), .x_is_load(x_is_load),
        .m_dst(m_dst), .m_we(m_we), .m_data(m_data), .m_st_src(m_st_src), .m_st_val(m_st_val),
        .w_dst(w_dst), .w_we(w_we), .w_data(w_data),
        .md_start(md_start), .md_dst(md_dst), .md_done(md_done),
        .x_fwd(x_fwd), .m_st_fwd(m_st_fwd), .stall(stall), .md_busy(md_busy),
        .stall_count(stall_count)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic string kind_name(input int k);
        case (k)
            K_XF0:   return "x_fwd0";
            K_XF1:   return "x_fwd1";
            K_STF:   return "m_st_fwd";
            K_STALL: return "stall";
            K_BUSY:  return "md_busy";
            default: return "stall_count";
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] observe(input int k);
        case (k)
            K_XF0:   return x_fwd[0 +: DATA_W];
            K_XF1:   return x_fwd[DATA_W +: DATA_W];
            K_STF:   return m_st_fwd;
            K_STALL: return DATA_W'(stall);
            K_BUSY:  return DATA_W'(md_busy);
            default: return DATA_W'(stall_count);
        endcase
    endfunction

    // Monitor: everything queued during a cycle is checked at the falling edge.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            logic [DATA_W-1:0] e;
            logic [DATA_W-1:0] a;
            int k;
            e = exp_q.pop_front();
            k = kind_q.pop_front();
            a = observe(k);
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got %h expected %h at %0t", kind_name(k), a, e, $time);
        end
    end

    // Driver tasks
    task automatic expect_out(input int k, input logic [DATA_W-1:0] v);
        exp_q.push_back(v);
        kind_q.push_back(k);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        d_src = '0; d_src_used = '0; d_dst = '0; d_we = 1'b0; d_is_md = 1'b0;
        x_src = '0; x_val = '0; x_dst = '0; x_we = 1'b0; x_is_load = 1'b0;
        m_dst = '0; m_we = 1'b0; m_data = '0; m_st_src = '0; m_st_val = '0;
        w_dst = '0; w_we = 1'b0; w_data = '0;
        md_start = 1'b0; md_dst = '0; md_done = 1'b0;
    endtask

    task automatic set_load_use();
        x_is_load = 1'b1; x_we = 1'b1; x_dst = 5'd4;
        d_src[0 +: REG_W] = 5'd4; d_src_used = 2'b01;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        clear_inputs();

        // Reset state
        step(); step();
        expect_out(K_STALL, 0); expect_out(K_BUSY, 0); expect_out(K_CNT, 0);
        step();
        reset_n = 1'b1;

        // M beats W; store data from W
        step(); clear_inputs();
        x_src[0 +: REG_W] = 5'd3; x_val[0 +: DATA_W] = 32'h0;
        m_dst = 5'd3; m_we = 1'b1; m_data = 32'hAAAA;
        w_dst = 5'd3; w_we = 1'b1; w_data = 32'hBBBB;
        m_st_src = 5'd3; m_st_val = 32'h1;
        expect_out(K_XF0, 32'hAAAA); expect_out(K_STF, 32'hBBBB);

        // r0 never forwarded; port 0 picks r3 from history
        step(); clear_inputs();
        x_src[DATA_W/DATA_W*REG_W +: REG_W] = 5'd0; x_val[DATA_W +: DATA_W] = 32'h0;
        m_dst = 5'd0; m_we = 1'b1; m_data = 32'h5;
        x_src[0 +: REG_W] = 5'd3; x_val[0 +: DATA_W] = 32'h11;
        expect_out(K_XF1, 32'h0); expect_out(K_STALL, 0); expect_out(K_XF0, 32'hBBBB);

        // W only
        step(); clear_inputs();
        x_src[0 +: REG_W] = 5'd5; w_dst = 5'd5; w_we = 1'b1; w_data = 32'h55;
        m_st_src = 5'd6; m_st_val = 32'hCAFE;
        expect_out(K_XF0, 32'h55); expect_out(K_STF, 32'hCAFE);

        // Load-use: one stall cycle
        step(); clear_inputs(); set_load_use();
        expect_out(K_STALL, 1); expect_out(K_CNT, 0);
        step(); clear_inputs();
        expect_out(K_STALL, 0); expect_out(K_CNT, 1);
        step(); clear_inputs(); set_load_use(); d_src_used = 2'b00;
        expect_out(K_STALL, 0); expect_out(K_CNT, 1);

        // Multdiv RAW on rt=7
        step(); clear_inputs();
        md_start = 1'b1; md_dst = 5'd7;
        d_src[REG_W +: REG_W] = 5'd7; d_src_used = 2'b10;
        expect_out(K_STALL, 0); expect_out(K_BUSY, 0);
        step(); clear_inputs(); d_src[REG_W +: REG_W] = 5'd7; d_src_used = 2'b10;
        expect_out(K_STALL, 1); expect_out(K_BUSY, 1); expect_out(K_CNT, 1);
        step();
        expect_out(K_STALL, 1); expect_out(K_CNT, 2);
        step(); md_done = 1'b1;
        expect_out(K_STALL, 1); expect_out(K_CNT, 3);
        step(); md_done = 1'b0;
        expect_out(K_STALL, 0); expect_out(K_BUSY, 0); expect_out(K_CNT, 4);

        // WAW, structural, then done+start on the same register
        step(); clear_inputs(); md_start = 1'b1; md_dst = 5'd7;
        expect_out(K_STALL, 0);
        step(); clear_inputs(); d_we = 1'b1; d_dst = 5'd7;
        expect_out(K_STALL, 1); expect_out(K_BUSY, 1); expect_out(K_CNT, 4);
        step(); clear_inputs(); d_is_md = 1'b1; d_dst = 5'd10;
        expect_out(K_STALL, 1); expect_out(K_CNT, 5);
        step(); clear_inputs(); md_done = 1'b1; md_start = 1'b1; md_dst = 5'd7;
        expect_out(K_STALL, 0); expect_out(K_CNT, 6);
        step(); clear_inputs(); d_src[0 +: REG_W] = 5'd7; d_src_used = 2'b01;
        expect_out(K_STALL, 1); expect_out(K_BUSY, 1); expect_out(K_CNT, 6);

        // Asynchronous reset mid-flight
        step(); reset_n = 1'b0;
        expect_out(K_STALL, 0); expect_out(K_BUSY, 0); expect_out(K_CNT, 0);
        step(); reset_n = 1'b1; clear_inputs();
        expect_out(K_BUSY, 0);

        // Stray done with nothing outstanding
        step(); md_done = 1'b1;
        step(); md_done = 1'b0;
        expect_out(K_BUSY, 0); expect_out(K_CNT, 0);

        // Write-back history forwarding
        step(); clear_inputs(); w_we = 1'b1; w_dst = 5'd9; w_data = 32'h1234;
        step(); clear_inputs();
        x_src[0 +: REG_W] = 5'd9; x_val[0 +: DATA_W] = 32'h0;
        m_st_src = 5'd9; m_st_val = 32'hDEAD;
        expect_out(K_XF0, 32'h1234); expect_out(K_STF, 32'h1234);
        step();
        expect_out(K_XF0, 32'h0); expect_out(K_STF, 32'hDEAD);

        // Counter saturation
        step(); clear_inputs(); set_load_use();
        for (int i = 0; i < (1 << CNT_W) + 5; i++) step();
        expect_out(K_CNT, 32'hFFFF); expect_out(K_STALL, 1);
        step(); clear_inputs();
        expect_out(K_CNT, 32'hFFFF);

        step(); step();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
